// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: walks a WORDS*16-bit add through one 16-bit carry-select slice, LSW first.
// Optional macro SUB_EN adds a 'sub' input that turns the operation into a - b.

module csa_16bit (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [4:0] s0;
    logic [4:0] s1;
    logic       c;

    // Four 4-bit blocks; each precomputes both carry-in outcomes and the incoming carry selects.
    always_comb begin
        s  = '0;
        s0 = '0;
        s1 = '0;
        c  = cin;
        for (int k = 0; k < 4; k++) begin
            s0 = 5'(x[4*k +: 4]) + 5'(y[4*k +: 4]);
            s1 = 5'(x[4*k +: 4]) + 5'(y[4*k +: 4]) + 5'd1;
            s[4*k +: 4] = c ? s1[3:0] : s0[3:0];
            c = c ? s1[4] : s0[4];
        end
        cout = c;
    end
endmodule

module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                cin,
`ifdef SUB_EN
    input  logic                sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] sum,
    output logic                cout
);
    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready and out_valid are registered FSM decodes and never depend on in_valid/out_ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [15:0]     slice_s;
    logic            slice_cout;
    logic [W-1:0]    b_eff;
    logic            cin_eff;

`ifdef SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Operand registers shift down one word per RUN cycle, so the slice always sees word 0.
    csa_16bit u_slice (
        .x    (a_q[15:0]),
        .y    (b_q[15:0]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b_eff;
                        carry    <= cin_eff;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (idx == IW'(k)) sum[16*k +: 16] <= slice_s;
                    end
                    carry <= slice_cout;
                    a_q   <= a_q >> 16;
                    b_q   <= b_q >> 16;
                    if (idx == IW'(WORDS - 1)) begin
                        cout      <= slice_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed cases plus random ops against a
// plain-arithmetic model, on a WORDS=4 and a WORDS=1 instance.

module tb_wide_add_sequencer;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- WORDS=4 instance ----------------
  logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
  logic [63:0] a4, b4, sum4;
  logic        sub4;
  // ---------------- WORDS=1 instance ----------------
  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
  logic [15:0] a1, b1, sum1;
  logic        sub1;

  wide_add_sequencer #(.WORDS(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
`ifdef SUB_EN
    .sub       (sub4),
`endif
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .cout      (cout4)
  );

  wide_add_sequencer #(.WORDS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
`ifdef SUB_EN
    .sub       (sub1),
`endif
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [64:0] exp_q[$];
  logic [16:0] exp1_q[$];

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [64:0] model4(input logic [63:0] a, input logic [63:0] b,
                                         input logic c, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + 65'd1;
    return {1'b0, a} + {1'b0, b} + 65'(c);
  endfunction

  function automatic logic [16:0] model1(input logic [15:0] a, input logic [15:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + 17'(c);
  endfunction

  // ---------------- drivers ----------------
  // Called and returning at 1 time unit after a rising edge.
  task automatic op4(input logic [63:0] a, input logic [63:0] b, input logic c,
                     input logic s, input int hold);
    logic [64:0] e;
    int n;
    n = 0;
    while (!in_ready4 && n < 50) begin @(posedge clk); #1; n++; end
    check("in4_ready", 65'(in_ready4), 65'd1);
    a4 = a; b4 = b; cin4 = c; sub4 = s; in_valid4 = 1'b1;
    exp_q.push_back(model4(a, b, c, s));
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    a4 = {$urandom, $urandom};
    b4 = {$urandom, $urandom};
    cin4 = ~c;
    n = 0;
    while (!out_valid4 && n < 50) begin @(posedge clk); #1; n++; end
    check("lat4", 65'(n), 65'd4);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h0;
    check("res4", {cout4, sum4}, e);
    check("busy4_in_ready", 65'(in_ready4), 65'd0);
    repeat (hold) begin
      in_valid4 = 1'b1;
      @(posedge clk); #1;
      check("hold4_valid", 65'(out_valid4), 65'd1);
      check("hold4_stable", {cout4, sum4}, e);
      check("hold4_in_ready", 65'(in_ready4), 65'd0);
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check("hs4_out_valid", 65'(out_valid4), 65'd0);
    check("hs4_in_ready", 65'(in_ready4), 65'd1);
    check("idle4_sum_kept", {cout4, sum4}, e);
  endtask

  task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] e;
    int n;
    n = 0;
    while (!in_ready1 && n < 20) begin @(posedge clk); #1; n++; end
    check("in1_ready", 65'(in_ready1), 65'd1);
    a1 = a; b1 = b; cin1 = c; in_valid1 = 1'b1;
    exp1_q.push_back(model1(a, b, c));
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    a1 = 16'($urandom);
    n = 0;
    while (!out_valid1 && n < 20) begin @(posedge clk); #1; n++; end
    check("lat1", 65'(n), 65'd1);
    e = (exp1_q.size() > 0) ? exp1_q.pop_front() : 17'h0;
    check("res1", 65'({cout1, sum1}), 65'(e));
    @(posedge clk); #1;
    check("hs1_in_ready", 65'(in_ready1), 65'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] ra, rb;
    logic        rs;
    rst = 1'b1;
    in_valid4 = 0; a4 = 0; b4 = 0; cin4 = 0; out_ready4 = 0; sub4 = 0;
    in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; out_ready1 = 1; sub1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 65'(in_ready4), 65'd1);
    check("rst_out_valid", 65'(out_valid4), 65'd0);
    check("rst_sum_cout", {cout4, sum4}, 65'd0);
    check("rst1_sum_cout", 65'({out_valid1, cout1, sum1}), 65'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // carry across a word boundary
    op4(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0);
    check("t1_const", {cout4, sum4}, {1'b0, 64'h0000_0000_0001_0000});
    // carry ripples through every word into cout
    op4(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0);
    check("t2_const", {cout4, sum4}, {1'b1, 64'h0});
    // back-pressure with a stray in_valid while busy
    op4(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 5);

    // reset in the middle of RUN
    a4 = 64'hDEAD_BEEF_0123_4567; b4 = 64'h1111_2222_3333_4444; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 65'(out_valid4), 65'd0);
    check("midrst_in_ready", 65'(in_ready4), 65'd1);
    check("midrst_sum", {cout4, sum4}, 65'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("postrst_out_valid", 65'(out_valid4), 65'd0);
    op4(64'h1234, 64'h1, 1'b0, 1'b0, 0);
    check("t4_const", {cout4, sum4}, {1'b0, 64'h1235});

`ifdef SUB_EN
    op4(64'h5, 64'h7, 1'b0, 1'b1, 0);
    check("t5a_const", {cout4, sum4}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    op4(64'h7, 64'h5, 1'b0, 1'b1, 0);
    check("t5b_const", {cout4, sum4}, {1'b1, 64'h2});
`endif

    // random WORDS=4 ops with mixed corner patterns and back-pressure
    for (int i = 0; i < 300; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: ;
        1: begin ra = '1; rb = 64'($urandom_range(0, 3)); end
        2: rb = ~ra;
        default: begin ra = '0; rb = '0; end
      endcase
`ifdef SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      op4(ra, rb, 1'($urandom_range(0, 1)), rs, $urandom_range(0, 2));
    end

    // WORDS=1
    op1(16'hFFFF, 16'h0001, 1'b0);
    check("t6_const", 65'({cout1, sum1}), 65'({1'b1, 16'h0000}));
    for (int i = 0; i < 1000; i++) begin
      op1(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
